// File: rtl/mips_cpu_pkg.sv
// mips_cpu_pkg: shared CPU datapath types and the data-memory arbiter state
package mips_cpu_pkg;
  typedef logic [31:0] reg_t;
  typedef logic [9:0] dm_addr_t;
  typedef enum logic [1:0] {IDLE, CPU_ACC, DMA_ACC} dm_arb_state_t;
endpackage

// File: rtl/dm_arbiter.sv
// dm_arbiter: shares one data-memory port between the MEM stage and a DMA loader
module dm_arbiter
  import mips_cpu_pkg::*;
#(
  parameter int WAIT_CYCLES  = 1,
  parameter int STARVE_LIMIT = 8
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     cpu_req,
  input  logic     cpu_we,
  input  dm_addr_t cpu_addr,
  input  reg_t     cpu_wdata,
  output reg_t     cpu_rdata,
  output logic     cpu_stall,
  input  logic     dma_req,
  input  logic     dma_we,
  input  dm_addr_t dma_addr,
  input  reg_t     dma_wdata,
  output reg_t     dma_rdata,
  output logic     dma_ack,
  output logic     dm_ce,
  output logic     dm_we,
  output dm_addr_t dm_addr,
  output reg_t     dm_din,
  input  reg_t     dm_dout
);
  localparam int CW = $clog2(WAIT_CYCLES + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LAST = CW'(WAIT_CYCLES - 1);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_LIMIT);
  if (WAIT_CYCLES < 1) begin : g_bad_wait
    $error("dm_arbiter: WAIT_CYCLES must be at least 1");
  end
  dm_arb_state_t   state;
  logic [CW-1:0]   cnt;
  logic [SW-1:0]   starve_cnt;
  logic            fin, dma_win, cpu_win;
  assign fin       = state != IDLE && cnt == LAST;
  assign dma_win   = state == IDLE && dma_req && (starve_cnt == SMAX || !cpu_req);
  assign cpu_win   = state == IDLE && !dma_win && cpu_req;
  assign cpu_stall = cpu_req && !(state == CPU_ACC && fin);
  assign cpu_rdata = state == CPU_ACC && fin ? dm_dout : '0;
  assign dma_ack   = state == DMA_ACC && fin;
  assign dma_rdata = dma_ack ? dm_dout : '0;
  // dm_we/dm_addr/dm_din double as the latched request so the port is glitch-free
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      starve_cnt <= '0;
      dm_ce      <= 1'b0;
      dm_we      <= 1'b0;
      dm_addr    <= '0;
      dm_din     <= '0;
    end else begin
      starve_cnt <= !dma_req || dma_win ? '0 : starve_cnt == SMAX ? SMAX : starve_cnt + 1'b1;
      if (dma_win || cpu_win) begin
        state   <= dma_win ? DMA_ACC : CPU_ACC;
        cnt     <= '0;
        dm_ce   <= 1'b1;
        dm_we   <= dma_win ? dma_we : cpu_we;
        dm_addr <= dma_win ? dma_addr : cpu_addr;
        dm_din  <= dma_win ? dma_wdata : cpu_wdata;
      end else if (state != IDLE) begin
        cnt <= cnt + 1'b1;
        if (fin) begin
          state <= IDLE;
          dm_ce <= 1'b0;
          dm_we <= 1'b0;
        end
      end
    end
endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: directed and randomized checks of dm_arbiter against a transaction-level model
module tb_dm_arbiter;
  import mips_cpu_pkg::*;
  localparam int W = 2;
  localparam int L = 4;
  logic clk = 1'b0, rst = 1'b1;
  logic cpu_req = 0, cpu_we = 0, dma_req = 0, dma_we = 0;
  dm_addr_t cpu_addr = '0, dma_addr = '0;
  reg_t cpu_wdata = '0, dma_wdata = '0, dm_dout = '0;
  reg_t cpu_rdata, dma_rdata, dm_din;
  logic cpu_stall, dma_ack, dm_ce, dm_we;
  dm_addr_t dm_addr;
  always #5 clk = ~clk;
  dm_arbiter #(.WAIT_CYCLES(W), .STARVE_LIMIT(L)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(dma_rdata), .dma_ack(dma_ack),
    .dm_ce(dm_ce), .dm_we(dm_we), .dm_addr(dm_addr), .dm_din(dm_din), .dm_dout(dm_dout)
  );
  int vectors = 0, errors = 0;
  // model: remaining access cycles, owner and the captured request
  int m_busy = 0, m_starve = 0;
  bit m_cpu = 0, m_we = 0;
  dm_addr_t m_addr = '0;
  reg_t m_wdata = '0;
  wire [109:0] act = {cpu_stall, cpu_rdata, dma_ack, dma_rdata, dm_ce, dm_we, dm_addr, dm_din};
  function automatic logic [109:0] expv();
    bit cf = m_busy == 1 && m_cpu;
    bit df = m_busy == 1 && !m_cpu;
    return {cpu_req && !cf, cf ? dm_dout : 32'h0, df, df ? dm_dout : 32'h0,
            m_busy > 0, m_busy > 0 && m_we, m_addr, m_wdata};
  endfunction
  function automatic void model_reset();
    m_busy = 0; m_starve = 0; m_cpu = 0; m_we = 0; m_addr = '0; m_wdata = '0;
  endfunction
  function automatic void model_step();
    bit dw = 0;
    if (rst) begin
      model_reset();
      return;
    end
    if (m_busy == 0) begin
      dw = dma_req && (m_starve == L || !cpu_req);
      if (dw || cpu_req) begin
        m_busy = W; m_cpu = !dw;
        m_we = dw ? dma_we : cpu_we;
        m_addr = dw ? dma_addr : cpu_addr;
        m_wdata = dw ? dma_wdata : cpu_wdata;
      end
    end else m_busy--;
    m_starve = (!dma_req || dw) ? 0 : (m_starve < L ? m_starve + 1 : L);
  endfunction
  always @(posedge clk) model_step();
  task automatic quiesce();
    cpu_req = 0; dma_req = 0;
    repeat (W + 2) @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    for (int c = 0; c < 4; c++) begin
      cpu_req = c[0]; dma_req = 1; dm_dout = $urandom;
      @(negedge clk);
      vectors++;
      if (act !== expv()) begin errors++; $display("FAIL reset_outputs c=%0d got=%h exp=%h", c, act, expv()); end
      vectors++;
      if ({cpu_stall, dm_ce, dma_ack} !== {cpu_req, 2'b00}) begin
        errors++; $display("FAIL reset_stall c=%0d got=%b%b%b exp=%b00", c, cpu_stall, dm_ce, dma_ack, cpu_req);
      end
    end
    cpu_req = 0; dma_req = 0; rst = 0;
    @(posedge clk); #1;
  endtask
  task automatic test_cpu_load();
    quiesce();
    cpu_req = 1; cpu_we = 0; cpu_addr = 10'h10; cpu_wdata = $urandom; dm_dout = 32'hDEADBEEF;
    for (int c = 1; c <= 4; c++) begin
      if (c == 4) cpu_req = 0;
      @(negedge clk);
      vectors++;
      if (act !== expv()) begin errors++; $display("FAIL cpu_load_model c=%0d got=%h exp=%h", c, act, expv()); end
      vectors++;
      if ({cpu_stall, dm_ce, cpu_rdata} !== {1'(c < 3), 1'(c == 2 || c == 3), c == 3 ? 32'hDEADBEEF : 32'h0}) begin
        errors++; $display("FAIL cpu_load c=%0d got stall=%b ce=%b rdata=%h", c, cpu_stall, dm_ce, cpu_rdata);
      end
      @(posedge clk); #1;
    end
  endtask
  task automatic test_dma_store();
    int acks = 0;
    quiesce();
    dma_req = 1; dma_we = 1; dma_addr = 10'h20; dma_wdata = 32'h12345678; dm_dout = $urandom;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      acks += int'(dma_ack);
      vectors++;
      if (act !== expv()) begin errors++; $display("FAIL dma_store_model c=%0d got=%h exp=%h", c, act, expv()); end
      vectors++;
      if ({dm_we, dma_ack} !== {1'(c == 2 || c == 3), 1'(c == 3)} || (c == 2 && {dm_addr, dm_din} !== {10'h20, 32'h12345678})) begin
        errors++; $display("FAIL dma_store c=%0d got we=%b ack=%b addr=%h din=%h", c, dm_we, dma_ack, dm_addr, dm_din);
      end
      @(posedge clk); #1;
      if (c == 3) dma_req = 0;
    end
    vectors++;
    if (acks != 1) begin errors++; $display("FAIL dma_ack_count got=%0d exp=1", acks); end
  endtask
  task automatic test_collision();
    quiesce();
    cpu_req = 1; cpu_we = 1; cpu_addr = 10'h55; cpu_wdata = $urandom;
    dma_req = 1; dma_we = 0; dma_addr = 10'h66; dm_dout = $urandom;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      vectors++;
      if (act !== expv()) begin errors++; $display("FAIL collision_model c=%0d got=%h exp=%h", c, act, expv()); end
      if (c == 2 || c == 5 || c == 6) begin
        vectors++;
        if (dm_addr !== (c == 2 ? 10'h55 : 10'h66) || (c == 6 && !(dma_ack && cpu_stall))) begin
          errors++; $display("FAIL collision_order c=%0d got addr=%h ack=%b stall=%b", c, dm_addr, dma_ack, cpu_stall);
        end
      end
      @(posedge clk); #1;
      cpu_req = c != 3;
      if (c == 6) dma_req = 0;
      if (c == 8) cpu_req = 0;
    end
  endtask
  task automatic test_starvation();
    quiesce();
    cpu_req = 1; cpu_we = 0; cpu_addr = 10'h01;
    dma_req = 1; dma_we = 1; dma_addr = 10'h02; dma_wdata = $urandom;
    for (int c = 1; c <= 13; c++) begin
      dm_dout = $urandom;
      @(negedge clk);
      vectors++;
      if (act !== expv()) begin errors++; $display("FAIL starve_model c=%0d got=%h exp=%h", c, act, expv()); end
      vectors++;
      if (dma_ack !== (c == 9) || (c == 12 && cpu_stall !== 1'b0)) begin
        errors++; $display("FAIL starvation c=%0d got ack=%b stall=%b", c, dma_ack, cpu_stall);
      end
      @(posedge clk); #1;
    end
  endtask
  task automatic test_reset_mid_access();
    quiesce();
    dma_req = 1; dma_we = 1; dma_addr = 10'h2A; dma_wdata = $urandom;
    @(posedge clk); #1;
    vectors++;
    if (dm_ce !== 1'b1) begin errors++; $display("FAIL rst_mid_pre got ce=%b exp=1", dm_ce); end
    rst = 1; model_reset();
    #1;
    vectors++;
    if ({dm_ce, dm_we, dm_addr, dma_ack} !== '0) begin
      errors++; $display("FAIL rst_mid_async got ce=%b we=%b addr=%h ack=%b exp=0", dm_ce, dm_we, dm_addr, dma_ack);
    end
    @(negedge clk);
    rst = 0; dma_req = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      vectors++;
      if (act !== expv() || dma_ack !== 1'b0) begin
        errors++; $display("FAIL rst_mid_after c=%0d got=%h exp=%h", c, act, expv());
      end
    end
    @(posedge clk); #1;
  endtask
  task automatic test_input_change();
    quiesce();
    cpu_req = 1; cpu_we = 1; cpu_addr = 10'h10; cpu_wdata = 32'hA5A5_0001;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      vectors++;
      if (act !== expv()) begin errors++; $display("FAIL hold_model c=%0d got=%h exp=%h", c, act, expv()); end
      if (c == 2 || c == 3) begin
        vectors++;
        if ({dm_addr, dm_din} !== {10'h10, 32'hA5A5_0001}) begin
          errors++; $display("FAIL hold_latched c=%0d got addr=%h din=%h", c, dm_addr, dm_din);
        end
      end
      @(posedge clk); #1;
      cpu_addr = 10'h3FF; cpu_wdata = $urandom; dma_req = c == 2;
      if (c == 3) begin cpu_req = 0; dma_req = 0; end
    end
  endtask
  task automatic test_random();
    bit drop = 0;
    quiesce();
    for (int i = 0; i < 500; i++) begin
      cpu_req = ($urandom % 3) != 0; cpu_we = $urandom; cpu_addr = $urandom; cpu_wdata = $urandom;
      if (drop) begin dma_req = 0; drop = 0; end
      else if (!dma_req && ($urandom % 3) == 0) begin
        dma_req = 1; dma_we = $urandom; dma_addr = $urandom; dma_wdata = $urandom;
      end
      dm_dout = $urandom;
      @(negedge clk);
      vectors++;
      if (act !== expv()) begin errors++; $display("FAIL random i=%0d got=%h exp=%h", i, act, expv()); end
      drop = dma_ack;
      @(posedge clk); #1;
    end
  endtask
  initial begin
    test_reset();
    test_cpu_load();
    test_dma_store();
    test_collision();
    test_starvation();
    test_reset_mid_access();
    test_input_change();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
